// File: rtl/uart_ee_pkg.sv
// Shared definitions for the UART-to-EEPROM command controller:
// state encoding, default frame headers and a width helper.
package uart_ee_pkg;

    typedef enum logic [3:0] {
        ST_H0      = 4'd0,
        ST_H1      = 4'd1,
        ST_ADDR    = 4'd2,
        ST_LEN     = 4'd3,
        ST_DATA    = 4'd4,
        ST_WR_REQ  = 4'd5,
        ST_WR_WAIT = 4'd6,
        ST_RD_REQ  = 4'd7,
        ST_RD_XFER = 4'd8
    } state_e;

    localparam logic [15:0] DEF_WR_HEADER = 16'hEEC0;
    localparam logic [15:0] DEF_RD_HEADER = 16'hEEC1;

    // Pointer width for a memory of 'value' entries, never less than one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_ee_buf.sv
// Byte RAM with write/read pointers and fill count; serves as the linear
// write-payload buffer and as the circular read-return FIFO.
module uart_ee_buf
    import uart_ee_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int            AW   = clog2_min1(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]    count_q, count_d;
    logic [7:0]    rd_data_q;
    logic          wr_s;

    assign wr_s = wr_en_i & ~clr_i;

    // Next pointer and count values, wrapping at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 9'd0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_i) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   count_d = count_q + 9'd1;
                2'b01:   count_d = count_q - 9'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage array; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, count and the registered head byte, which already reflects
    // the advanced read pointer; a write to that slot is bypassed through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 9'd0;
            rd_data_q <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_s && (wr_ptr_q == rd_ptr_d)) begin
                rd_data_q <= wr_data_i;
            end else begin
                rd_data_q <= mem_q[rd_ptr_d];
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign full_o    = (count_q == 9'(DEPTH));
    assign empty_o   = (count_q == 9'd0);

endmodule

// File: rtl/uart_eeprom_cmd_ctrl.sv
// Parses framed write/read commands from the UART RX stream, drives the IIC
// EEPROM byte engine and streams read data back to UART TX.
module uart_eeprom_cmd_ctrl
    import uart_ee_pkg::*;
#(
    parameter int          MAX_BYTE_NUM   = 64,
    parameter int          ADDR_BYTES     = 3,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [15:0] WR_HEADER      = DEF_WR_HEADER,
    parameter logic [15:0] RD_HEADER      = DEF_RD_HEADER,
    localparam int         ADDR_W         = 8 * ADDR_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              wr_byte_req,
    output logic [7:0]        wr_byte_num_sub1,
    output logic [ADDR_W-1:0] wr_byte_addr,
    output logic [7:0]        wr_byte_data,
    input  logic              wr_byte_rden,
    input  logic              wr_byte_busy,
    output logic              rd_byte_req,
    output logic [7:0]        rd_byte_num_sub1,
    output logic [ADDR_W-1:0] rd_byte_addr,
    input  logic [7:0]        rd_byte_data,
    input  logic              rd_byte_data_valid,
    input  logic              rd_byte_busy,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    input  logic              tx_ready,
    output logic              frame_err
);

    state_e            state_q;
    logic              mode_rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        addr_cnt_q;
    logic [7:0]        num_sub1_q;
    logic [8:0]        byte_cnt_q;
    logic [8:0]        rd_idx_q;
    logic [31:0]       timer_q;
    logic              wr_busy_q, rd_busy_q;
    logic              fall_seen_q, stray_q;
    logic              wr_req_q, rd_req_q, frame_err_q;

    logic       wr_rise_s, wr_fall_s, rd_rise_s, rd_fall_s;
    logic       timed_s, timeout_s, len_ok_s, busy_state_s;
    logic       wr_adv_s, tx_pop_s, overflow_s;
    logic       buf_clr_s, buf_wr_s, buf_rd_s, buf_full_s, buf_empty_s;
    logic [7:0] buf_wdata_s, buf_rdata_s;
    logic [8:0] num_s;

    assign wr_rise_s = wr_byte_busy & ~wr_busy_q;
    assign wr_fall_s = ~wr_byte_busy & wr_busy_q;
    assign rd_rise_s = rd_byte_busy & ~rd_busy_q;
    assign rd_fall_s = ~rd_byte_busy & rd_busy_q;
    assign num_s     = {1'b0, num_sub1_q} + 9'd1;

    // Buffer control and frame-level qualifiers derived from current state.
    always_comb begin
        timed_s      = (state_q == ST_H1) || (state_q == ST_ADDR) ||
                       (state_q == ST_LEN) || (state_q == ST_DATA);
        busy_state_s = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT) ||
                       (state_q == ST_RD_REQ) || (state_q == ST_RD_XFER);
        timeout_s    = timed_s && !rx_data_valid &&
                       (timer_q == 32'(TIMEOUT_CYCLES - 1));
        len_ok_s     = (rx_data != 8'd0) && ({1'b0, rx_data} <= 9'(MAX_BYTE_NUM));
        wr_adv_s     = ((state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT)) &&
                       wr_byte_rden && (rd_idx_q < {1'b0, num_sub1_q});
        tx_pop_s     = tx_data_valid && tx_ready;
        overflow_s   = (state_q == ST_RD_XFER) && rd_byte_data_valid && buf_full_s;
        buf_clr_s    = (state_q == ST_LEN) && rx_data_valid && len_ok_s;
        buf_rd_s     = wr_adv_s || tx_pop_s;
        if (state_q == ST_DATA) begin
            buf_wr_s    = rx_data_valid;
            buf_wdata_s = rx_data;
        end else begin
            buf_wr_s    = (state_q == ST_RD_XFER) && rd_byte_data_valid && !buf_full_s;
            buf_wdata_s = rd_byte_data;
        end
    end

    uart_ee_buf #(
        .DEPTH (MAX_BYTE_NUM)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (buf_clr_s),
        .wr_en_i   (buf_wr_s),
        .wr_data_i (buf_wdata_s),
        .rd_en_i   (buf_rd_s),
        .rd_data_o (buf_rdata_s),
        .full_o    (buf_full_s),
        .empty_o   (buf_empty_s)
    );

    // Command FSM with its counters and registered request/error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_H0;
            mode_rd_q   <= 1'b0;
            addr_q      <= '0;
            addr_cnt_q  <= 3'd0;
            num_sub1_q  <= 8'd0;
            byte_cnt_q  <= 9'd0;
            rd_idx_q    <= 9'd0;
            timer_q     <= 32'd0;
            wr_busy_q   <= 1'b0;
            rd_busy_q   <= 1'b0;
            fall_seen_q <= 1'b0;
            stray_q     <= 1'b0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_busy_q   <= wr_byte_busy;
            rd_busy_q   <= rd_byte_busy;
            frame_err_q <= 1'b0;
            if (rx_data_valid || !timed_s) begin
                timer_q <= 32'd0;
            end else begin
                timer_q <= timer_q + 32'd1;
            end
            // Only the first stray RX byte of a command is reported.
            if (busy_state_s && rx_data_valid && !stray_q) begin
                stray_q     <= 1'b1;
                frame_err_q <= 1'b1;
            end
            if (wr_adv_s) begin
                rd_idx_q <= rd_idx_q + 9'd1;
            end
            case (state_q)
                ST_H0: begin
                    if (rx_data_valid && ((rx_data == WR_HEADER[15:8]) ||
                                          (rx_data == RD_HEADER[15:8]))) begin
                        state_q <= ST_H1;
                    end
                end
                ST_H1: begin
                    if (rx_data_valid) begin
                        addr_cnt_q <= 3'd0;
                        if (rx_data == WR_HEADER[7:0]) begin
                            mode_rd_q <= 1'b0;
                            state_q   <= ST_ADDR;
                        end else if (rx_data == RD_HEADER[7:0]) begin
                            mode_rd_q <= 1'b1;
                            state_q   <= ST_ADDR;
                        end else if ((rx_data == WR_HEADER[15:8]) ||
                                     (rx_data == RD_HEADER[15:8])) begin
                            state_q <= ST_H1;
                        end else begin
                            state_q <= ST_H0;
                        end
                    end else if (timeout_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_H0;
                    end
                end
                ST_ADDR: begin
                    if (rx_data_valid) begin
                        addr_q     <= (addr_q << 8) | ADDR_W'(rx_data);
                        addr_cnt_q <= addr_cnt_q + 3'd1;
                        if (addr_cnt_q == 3'(ADDR_BYTES - 1)) begin
                            state_q <= ST_LEN;
                        end
                    end else if (timeout_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_H0;
                    end
                end
                ST_LEN: begin
                    if (rx_data_valid) begin
                        if (!len_ok_s) begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_H0;
                        end else begin
                            num_sub1_q <= rx_data - 8'd1;
                            byte_cnt_q <= 9'd0;
                            rd_idx_q   <= 9'd0;
                            stray_q    <= 1'b0;
                            if (mode_rd_q) begin
                                rd_req_q <= 1'b1;
                                state_q  <= ST_RD_REQ;
                            end else begin
                                state_q <= ST_DATA;
                            end
                        end
                    end else if (timeout_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_H0;
                    end
                end
                ST_DATA: begin
                    if (rx_data_valid) begin
                        byte_cnt_q <= byte_cnt_q + 9'd1;
                        if (byte_cnt_q == {1'b0, num_sub1_q}) begin
                            rd_idx_q <= 9'd0;
                            wr_req_q <= 1'b1;
                            state_q  <= ST_WR_REQ;
                        end
                    end else if (timeout_s) begin
                        frame_err_q <= 1'b1;
                        state_q     <= ST_H0;
                    end
                end
                ST_WR_REQ: begin
                    if (wr_rise_s) begin
                        wr_req_q <= 1'b0;
                        state_q  <= ST_WR_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (wr_fall_s) begin
                        state_q <= ST_H0;
                    end
                end
                ST_RD_REQ: begin
                    if (rd_rise_s) begin
                        rd_req_q    <= 1'b0;
                        fall_seen_q <= 1'b0;
                        state_q     <= ST_RD_XFER;
                    end
                end
                ST_RD_XFER: begin
                    if (rd_fall_s) begin
                        fall_seen_q <= 1'b1;
                    end
                    if (overflow_s) begin
                        frame_err_q <= 1'b1;
                    end
                    if (tx_pop_s) begin
                        byte_cnt_q <= byte_cnt_q + 9'd1;
                    end
                    if ((fall_seen_q || rd_fall_s) && (byte_cnt_q == num_s)) begin
                        state_q <= ST_H0;
                    end
                end
                default: begin
                    state_q <= ST_H0;
                end
            endcase
        end
    end

    assign wr_byte_req      = wr_req_q;
    assign wr_byte_num_sub1 = num_sub1_q;
    assign wr_byte_addr     = addr_q;
    assign wr_byte_data     = buf_rdata_s;
    assign rd_byte_req      = rd_req_q;
    assign rd_byte_num_sub1 = num_sub1_q;
    assign rd_byte_addr     = addr_q;
    assign tx_data          = buf_rdata_s;
    assign tx_data_valid    = (state_q == ST_RD_XFER) && !buf_empty_s;
    assign frame_err        = frame_err_q;

endmodule

// File: tb/tb_uart_eeprom_cmd_ctrl.sv
// Directed self-checking bench for uart_eeprom_cmd_ctrl.
module tb_uart_eeprom_cmd_ctrl;
    import uart_ee_pkg::*;

    localparam int MAXN = 8;
    localparam int AB   = 3;
    localparam int TO   = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        wr_byte_req;
    logic [7:0]  wr_byte_num_sub1;
    logic [23:0] wr_byte_addr;
    logic [7:0]  wr_byte_data;
    logic        wr_byte_rden;
    logic        wr_byte_busy;
    logic        rd_byte_req;
    logic [7:0]  rd_byte_num_sub1;
    logic [23:0] rd_byte_addr;
    logic [7:0]  rd_byte_data;
    logic        rd_byte_data_valid;
    logic        rd_byte_busy;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_ready = 1'b0;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int wr_req_cnt = 0;
    int tx_cnt = 0;
    logic [7:0] tx_log [256];
    logic       tx_en = 1'b0;
    logic [7:0] fq [$];
    logic [7:0] rq [$];
    int e0, t0, w0;

    uart_eeprom_cmd_ctrl #(
        .MAX_BYTE_NUM   (MAXN),
        .ADDR_BYTES     (AB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_data            (rx_data),
        .rx_data_valid      (rx_data_valid),
        .wr_byte_req        (wr_byte_req),
        .wr_byte_num_sub1   (wr_byte_num_sub1),
        .wr_byte_addr       (wr_byte_addr),
        .wr_byte_data       (wr_byte_data),
        .wr_byte_rden       (wr_byte_rden),
        .wr_byte_busy       (wr_byte_busy),
        .rd_byte_req        (rd_byte_req),
        .rd_byte_num_sub1   (rd_byte_num_sub1),
        .rd_byte_addr       (rd_byte_addr),
        .rd_byte_data       (rd_byte_data),
        .rd_byte_data_valid (rd_byte_data_valid),
        .rd_byte_busy       (rd_byte_busy),
        .tx_data            (tx_data),
        .tx_data_valid      (tx_data_valid),
        .tx_ready           (tx_ready),
        .frame_err          (frame_err)
    );

    always #5 clk = ~clk;

    // UART TX side alternates ready every cycle while enabled.
    always @(posedge clk) begin
        #1;
        if (tx_en) tx_ready = ~tx_ready;
        else       tx_ready = 1'b0;
    end

    // Monitor: error pulses, write-request cycles and accepted TX bytes.
    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (wr_byte_req) wr_req_cnt++;
        if (tx_data_valid && tx_ready) begin
            tx_log[tx_cnt[7:0]] = tx_data;
            tx_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_data_valid = 1'b1;
        @(posedge clk); #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic send_fq();
        foreach (fq[i]) send_byte(fq[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel 0: wr_byte_req, 1: rd_byte_req, other: FSM back in H0.
    task automatic wait_cond(input string tag, input int sel);
        logic met;
        met = 1'b0;
        for (int i = 0; i < 200 && !met; i++) begin
            @(negedge clk);
            case (sel)
                0:       met = wr_byte_req;
                1:       met = rd_byte_req;
                default: met = (dut.state_q == ST_H0);
            endcase
        end
        check_val(tag, 32'(met), 32'd1);
    endtask

    task automatic push_rq();
        foreach (rq[i]) begin
            @(posedge clk); #1;
            rd_byte_data = rq[i];
            rd_byte_data_valid = 1'b1;
        end
        @(posedge clk); #1;
        rd_byte_data_valid = 1'b0;
    endtask

    task automatic rd_finish(input string tag);
        @(posedge clk); #1; rd_byte_busy = 1'b1;
        idle(2);
        push_rq();
        idle(2);
        rd_byte_busy = 1'b0;
        wait_cond(tag, 2);
    endtask

    task automatic wr_pulse_rden();
        @(posedge clk); #1; wr_byte_rden = 1'b1;
        @(posedge clk); #1; wr_byte_rden = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] tx_at(input int k);
        return (k < tx_cnt) ? {24'd0, tx_log[k[7:0]]} : 32'hxxxx_xxxx;
    endfunction

    initial begin
        logic [7:0] exp_w [4];
        logic [7:0] exp_r [3];
        exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_r = '{8'hA5, 8'h5A, 8'hFF};
        rst = 1'b1;
        rx_data = 8'd0; rx_data_valid = 1'b0;
        wr_byte_rden = 1'b0; wr_byte_busy = 1'b0;
        rd_byte_data = 8'd0; rd_byte_data_valid = 1'b0; rd_byte_busy = 1'b0;
        idle(3);
        check_val("rst_wr_req", 32'(wr_byte_req), 32'd0);
        check_val("rst_rd_req", 32'(rd_byte_req), 32'd0);
        check_val("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        check_val("rst_addr", 32'(wr_byte_addr), 32'd0);
        rst = 1'b0;
        idle(2);

        // Write N=4.
        e0 = err_cnt;
        fq = '{8'hEE, 8'hC0, 8'h00, 8'h01, 8'h20, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_fq();
        wait_cond("wr_req", 0);
        check_val("wr_addr", 32'(wr_byte_addr), 32'h000120);
        check_val("wr_num", 32'(wr_byte_num_sub1), 32'd3);
        @(posedge clk); #1; wr_byte_busy = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("wr_req_drop", 32'(wr_byte_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val($sformatf("wr_data%0d", k), 32'(wr_byte_data), 32'(exp_w[k]));
            wr_pulse_rden();
        end
        wr_pulse_rden();
        @(negedge clk);
        check_val("wr_sat", 32'(wr_byte_data), 32'h44);
        @(posedge clk); #1; wr_byte_busy = 1'b0;
        wait_cond("wr_h0", 2);
        check_val("wr_no_err", 32'(err_cnt - e0), 32'd0);

        // Read N=3 with toggling TX ready.
        e0 = err_cnt; t0 = tx_cnt; tx_en = 1'b1;
        fq = '{8'hEE, 8'hC1, 8'h00, 8'h00, 8'h10, 8'h03};
        send_fq();
        wait_cond("rd_req", 1);
        check_val("rd_addr", 32'(rd_byte_addr), 32'h000010);
        check_val("rd_num", 32'(rd_byte_num_sub1), 32'd2);
        @(posedge clk); #1; rd_byte_busy = 1'b1;
        @(posedge clk); @(negedge clk);
        check_val("rd_req_drop", 32'(rd_byte_req), 32'd0);
        rq = '{8'hA5, 8'h5A, 8'hFF};
        push_rq();
        idle(3);
        rd_byte_busy = 1'b0;
        wait_cond("rd_h0", 2);
        check_val("rd_tx_cnt", 32'(tx_cnt - t0), 32'd3);
        for (int k = 0; k < 3; k++)
            check_val($sformatf("rd_tx%0d", k), tx_at(t0 + k), 32'(exp_r[k]));
        check_val("rd_no_err", 32'(err_cnt - e0), 32'd0);
        tx_en = 1'b0;

        // Illegal lengths: zero and MAXN+1.
        e0 = err_cnt; w0 = wr_req_cnt;
        fq = '{8'hEE, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00};
        send_fq();
        idle(5);
        check_val("len0_err", 32'(err_cnt - e0), 32'd1);
        fq = '{8'hEE, 8'hC0, 8'h00, 8'h00, 8'h00, 8'(MAXN + 1)};
        send_fq();
        idle(5);
        check_val("lenmax_err", 32'(err_cnt - e0), 32'd2);
        check_val("len_no_req", 32'(wr_req_cnt - w0), 32'd0);
        check_val("len_h0", 32'(dut.state_q == ST_H0), 32'd1);

        // Header resync on a doubled high byte, then a broken pair.
        e0 = err_cnt;
        fq = '{8'hEE, 8'hEE, 8'hC0, 8'h00, 8'h00, 8'h40, 8'h01, 8'h5A};
        send_fq();
        wait_cond("rs_wr_req", 0);
        check_val("rs_wr_addr", 32'(wr_byte_addr), 32'h000040);
        check_val("rs_wr_data", 32'(wr_byte_data), 32'h5A);
        @(posedge clk); #1; wr_byte_busy = 1'b1;
        idle(3);
        wr_byte_busy = 1'b0;
        wait_cond("rs_wr_h0", 2);
        t0 = tx_cnt; tx_en = 1'b1;
        fq = '{8'hEE, 8'h12, 8'hEE, 8'hC1, 8'h00, 8'h00, 8'h20, 8'h01};
        send_fq();
        wait_cond("rs_rd_req", 1);
        check_val("rs_rd_addr", 32'(rd_byte_addr), 32'h000020);
        rq = '{8'h3C};
        rd_finish("rs_rd_h0");
        check_val("rs_tx", tx_at(t0), 32'h3C);
        check_val("rs_no_err", 32'(err_cnt - e0), 32'd0);

        // Inter-byte timeout in ADDR, then recovery.
        e0 = err_cnt;
        fq = '{8'hEE, 8'hC0, 8'h00};
        send_fq();
        idle(TO - 10);
        check_val("to_early", 32'(err_cnt - e0), 32'd0);
        idle(20);
        check_val("to_err", 32'(err_cnt - e0), 32'd1);
        check_val("to_h0", 32'(dut.state_q == ST_H0), 32'd1);
        t0 = tx_cnt;
        fq = '{8'hEE, 8'hC1, 8'h00, 8'h00, 8'h08, 8'h01};
        send_fq();
        wait_cond("to_rd_req", 1);
        check_val("to_rd_addr", 32'(rd_byte_addr), 32'h000008);
        rq = '{8'hC3};
        rd_finish("to_rd_h0");
        check_val("to_tx", tx_at(t0), 32'hC3);
        tx_en = 1'b0;

        // Stray bytes in WR_WAIT, then reset mid-write.
        fq = '{8'hEE, 8'hC0, 8'h00, 8'h00, 8'h30, 8'h01, 8'h77};
        send_fq();
        wait_cond("mr_wr_req", 0);
        @(posedge clk); #1; wr_byte_busy = 1'b1;
        idle(2);
        e0 = err_cnt;
        send_byte(8'h55);
        send_byte(8'h66);
        idle(2);
        check_val("stray_err", 32'(err_cnt - e0), 32'd1);
        check_val("mr_in_wait", 32'(dut.state_q == ST_WR_WAIT), 32'd1);
        rst = 1'b1;
        #1;
        check_val("mr_wr_req", 32'(wr_byte_req), 32'd0);
        check_val("mr_addr", 32'(wr_byte_addr), 32'd0);
        check_val("mr_num", 32'(wr_byte_num_sub1), 32'd0);
        check_val("mr_data", 32'(wr_byte_data), 32'd0);
        check_val("mr_h0", 32'(dut.state_q == ST_H0), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        wr_byte_busy = 1'b0;
        w0 = wr_req_cnt;
        idle(10);
        check_val("mr_no_req", 32'(wr_req_cnt - w0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
